// File: rtl/word_mem_rw.sv
// word_mem_rw: byte-addressed table memory with big-endian word access.
// Requests use a valid/ready channel. Each accepted request produces one
// registered response on the following cycle, and there is no backpressure.
// Any request that touches a byte at or above MEM_DEPTH is rejected whole.
// It writes nothing and reports rsp_err.
// An optional clear sequencer zeroes the whole array after every reset.
module word_mem_rw #(
   parameter int ADDR_WIDTH     = 16,
   parameter int MEM_DEPTH      = 2048,
   parameter int WORD_BYTES     = 2,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clock,
   input  logic                    nrst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [8*WORD_BYTES-1:0] req_wdata,
   input  logic [WORD_BYTES-1:0]   req_be,
   output logic                    rsp_valid,
   output logic [8*WORD_BYTES-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    busy
);

   localparam int DATA_W = 8 * WORD_BYTES;
   localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int AW1    = ADDR_WIDTH + 1;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   localparam state_t           RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
   localparam logic [IDX_W-1:0] CLR_LAST  = IDX_W'(MEM_DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [AW1-1:0]   DEPTH_LIM = AW1'(MEM_DEPTH);
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   state_t             state_r;
   state_t             state_nxt_s;
   logic [IDX_W-1:0]   clr_cnt_r;
   logic               ready_r;
   logic               busy_r;
   logic               ready_nxt_s;
   logic               busy_nxt_s;
   logic               clr_we_s;
   logic               accept_s;
   logic               err_s;
   logic [AW1-1:0]     last_addr_s;
   logic [IDX_W-1:0]   idx_s [WORD_BYTES];
   logic [DATA_W-1:0]  rd_word_s;
   logic               rsp_valid_r;
   logic [DATA_W-1:0]  rsp_rdata_r;
   logic               rsp_err_r;
   logic [7:0]         mem_r [MEM_DEPTH];

   // FSM state register: reset returns to the clear sequence (or straight to IDLE)
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state_r <= RST_STATE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: INIT leaves on the cycle that clears the last byte
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (clr_cnt_r == CLR_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_IDLE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = RST_STATE;
      endcase
   end

   // FSM outputs: clear strobe from the current state; ready/busy are prepared from the next state
   always_comb begin
      clr_we_s    = 1'b0;
      ready_nxt_s = 1'b0;
      busy_nxt_s  = 1'b0;
      case (state_r)
         ST_INIT: clr_we_s = 1'b1;
         ST_IDLE: clr_we_s = 1'b0;
         default: clr_we_s = 1'b0;
      endcase
      case (state_nxt_s)
         ST_INIT: begin
            ready_nxt_s = 1'b0;
            busy_nxt_s  = 1'b1;
         end
         ST_IDLE: begin
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
         end
         default: begin
            ready_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // Registered handshake/status outputs; ready is low throughout reset
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         ready_r <= 1'b0;
         busy_r  <= CLEAR_ON_RESET;
      end else begin
         ready_r <= ready_nxt_s;
         busy_r  <= busy_nxt_s;
      end
   end

   // Clear address counter: walks 0..MEM_DEPTH-1 while in INIT
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         clr_cnt_r <= IDX_ZERO;
      end else if (clr_we_s) begin
         if (clr_cnt_r == CLR_LAST) begin
            clr_cnt_r <= IDX_ZERO;
         end else begin
            clr_cnt_r <= clr_cnt_r + IDX_W'(1);
         end
      end else begin
         clr_cnt_r <= IDX_ZERO;
      end
   end

   // Request decode: extended-width range check (no wrap) and per-byte indices
   always_comb begin
      accept_s    = req_valid & ready_r;
      last_addr_s = {1'b0, req_addr} + AW1'(WORD_BYTES - 1);
      err_s       = (last_addr_s >= DEPTH_LIM);
      for (int k = 0; k < WORD_BYTES; k++) begin
         idx_s[k] = IDX_W'({1'b0, req_addr} + AW1'(k));
      end
   end

   // Big-endian word assembly: word byte 0 (MSB) comes from the lowest address
   always_comb begin
      rd_word_s = DATA_ZERO;
      for (int k = 0; k < WORD_BYTES; k++) begin
         rd_word_s[DATA_W-8-8*k +: 8] = mem_r[idx_s[k]];
      end
   end

   // Storage: clear sequencer has priority; otherwise only error-free writes update enabled bytes
   always_ff @(posedge clock) begin
      if (clr_we_s) begin
         mem_r[clr_cnt_r] <= 8'h00;
      end else if (accept_s && req_wr && !err_s) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            if (req_be[WORD_BYTES-1-k]) begin
               mem_r[idx_s[k]] <= req_wdata[DATA_W-8-8*k +: 8];
            end
         end
      end
   end

   // Response pipeline: one pulse per accept; data/error hold between pulses
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= DATA_ZERO;
         rsp_err_r   <= 1'b0;
      end else begin
         rsp_valid_r <= accept_s;
         if (accept_s) begin
            rsp_err_r <= err_s;
            if (!req_wr && !err_s) begin
               rsp_rdata_r <= rd_word_s;
            end else begin
               rsp_rdata_r <= DATA_ZERO;
            end
         end
      end
   end

   assign req_ready = ready_r;
   assign busy      = busy_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_word_mem_rw.sv
// Scoreboard bench for word_mem_rw (depth 64, 16-bit words).
// A byte-array reference model predicts each response when its request is issued.
// A negedge monitor pops the predictions and compares them with the outputs.
// A second instance without the post-reset clear checks retention across reset.
module tb_word_mem_rw;

   localparam int DEPTH = 64;

   typedef struct {
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        nrst  = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [15:0] req_wdata = 16'h0000;
   logic [1:0]  req_be = 2'b00;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   logic        nrst0 = 1'b0;
   logic        v0 = 1'b0;
   logic        rdy0;
   logic        wr0 = 1'b0;
   logic [15:0] addr0 = 16'h0000;
   logic [15:0] wdata0 = 16'h0000;
   logic [1:0]  be0 = 2'b00;
   logic        rv0;
   logic [15:0] rdata0;
   logic        err0;
   logic        busy0;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [15:0] hold_data = 16'h0000;
   logic        hold_err  = 1'b0;
   logic [7:0]  ref_mem [DEPTH];

   word_mem_rw #(.ADDR_WIDTH(16), .MEM_DEPTH(DEPTH), .WORD_BYTES(2), .CLEAR_ON_RESET(1'b1)) dut (
      .clock(clock), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
   );

   word_mem_rw #(.ADDR_WIDTH(16), .MEM_DEPTH(DEPTH), .WORD_BYTES(2), .CLEAR_ON_RESET(1'b0)) dut0 (
      .clock(clock), .nrst(nrst0), .req_valid(v0), .req_ready(rdy0),
      .req_wr(wr0), .req_addr(addr0), .req_wdata(wdata0), .req_be(be0),
      .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0), .busy(busy0)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   // Reference model: every INIT leaves the array all zero
   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
   endtask

   // Drive one request for one cycle (entered just after a rising edge) and queue its prediction
   task automatic issue(input logic wr, input int a, input logic [15:0] d, input logic [1:0] be);
      exp_t e;
      logic err;
      check("ready_at_issue", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = 16'(a);
      req_wdata = d;
      req_be    = be;
      err       = (a + 1 >= DEPTH);
      e.err     = err;
      e.data    = 16'h0000;
      if (!err) begin
         if (wr) begin
            if (be[1]) ref_mem[a]     = d[15:8];
            if (be[0]) ref_mem[a + 1] = d[7:0];
         end else begin
            e.data = {ref_mem[a], ref_mem[a + 1]};
         end
      end
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      req_valid = 1'b0;
      @(posedge clock);
      #1;
   endtask

   // Release reset at a falling edge and count rising edges seen while busy
   task automatic release_and_init();
      int   cnt;
      logic ready_seen;
      cnt        = 0;
      ready_seen = 1'b0;
      @(negedge clock);
      nrst = 1'b1;
      while (busy === 1'b1 && cnt < 200) begin
         if (req_ready !== 1'b0) ready_seen = 1'b1;
         cnt++;
         @(posedge clock);
         #1;
      end
      model_clear();
      check("init_cycles", 32'(cnt), 32'd64);
      check("init_ready_low", {31'd0, ready_seen}, 32'd0);
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: reset values, scoreboard pops on rsp_valid, hold checks otherwise
   always @(negedge clock) begin
      if (!nrst) begin
         check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
         check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
         hold_data = 16'h0000;
         hold_err  = 1'b0;
      end else if (rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1, expected 0 (no request pending)");
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mon_e.data});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
            hold_data = mon_e.data;
            hold_err  = mon_e.err;
         end
      end else begin
         check("hold_rdata", {16'd0, rsp_rdata}, {16'd0, hold_data});
         check("hold_err", {31'd0, rsp_err}, {31'd0, hold_err});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      repeat (3) @(posedge clock);
      #1;
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst0_ready", {31'd0, rdy0}, 32'd0);
      check("rst0_busy", {31'd0, busy0}, 32'd0);

      release_and_init();

      // Directed cases
      issue(1'b0, 16'h3E, 16'h0000, 2'b00);
      issue(1'b1, 16'h08, 16'h00AB, 2'b11);
      issue(1'b0, 16'h08, 16'h0000, 2'b00);
      issue(1'b0, 16'h09, 16'h0000, 2'b00);
      issue(1'b1, 16'h10, 16'h1234, 2'b11);
      issue(1'b1, 16'h10, 16'hFFFF, 2'b01);
      issue(1'b0, 16'h10, 16'h0000, 2'b00);
      issue(1'b1, 16'h10, 16'h5A5A, 2'b00);
      issue(1'b0, 16'h10, 16'h0000, 2'b00);
      issue(1'b1, 16'h3F, 16'hBEEF, 2'b11);
      issue(1'b0, 16'h3E, 16'h0000, 2'b00);
      issue(1'b0, 16'h3F, 16'h0000, 2'b00);
      issue(1'b0, 16'h40, 16'h0000, 2'b00);
      idle_cycle();
      issue(1'b1, 16'h20, 16'h5555, 2'b11);
      issue(1'b0, 16'h20, 16'h0000, 2'b00);
      issue(1'b1, 16'h20, 16'hAAAA, 2'b11);
      issue(1'b0, 16'h20, 16'h0000, 2'b00);
      idle_cycle();
      idle_cycle();

      // Randomised traffic, including out-of-range and unaligned addresses
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle_cycle();
         end else begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 66)),
                  16'($urandom), 2'($urandom_range(0, 3)));
         end
      end
      issue(1'b1, 16'h20, 16'hC3C3, 2'b11);
      idle_cycle();
      idle_cycle();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      // Reset asserted while a read is being presented: no response, INIT repeats
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'h0020;
      #2;
      nrst = 1'b0;
      @(negedge clock);
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      release_and_init();
      issue(1'b0, 16'h20, 16'h0000, 2'b00);
      idle_cycle();
      idle_cycle();
      check("queue_drained2", 32'(exp_q.size()), 32'd0);

      // Instance without clear: ready right after release, contents survive reset
      @(negedge clock);
      nrst0 = 1'b1;
      @(posedge clock);
      #1;
      check("d0_ready_first", {31'd0, rdy0}, 32'd1);
      check("d0_busy", {31'd0, busy0}, 32'd0);
      v0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'hAAAA; be0 = 2'b11;
      @(posedge clock);
      #1;
      v0 = 1'b0;
      check("d0_wr_valid", {31'd0, rv0}, 32'd1);
      check("d0_wr_err", {31'd0, err0}, 32'd0);
      check("d0_wr_rdata", {16'd0, rdata0}, 32'd0);
      v0 = 1'b1; wr0 = 1'b0;
      @(posedge clock);
      #1;
      v0 = 1'b0;
      check("d0_rd_valid", {31'd0, rv0}, 32'd1);
      check("d0_rd_data", {16'd0, rdata0}, 32'h0000AAAA);
      @(negedge clock);
      nrst0 = 1'b0;
      #1;
      check("d0_rst_valid", {31'd0, rv0}, 32'd0);
      check("d0_rst_rdata", {16'd0, rdata0}, 32'd0);
      check("d0_rst_ready", {31'd0, rdy0}, 32'd0);
      @(negedge clock);
      nrst0 = 1'b1;
      @(posedge clock);
      #1;
      check("d0_ready_again", {31'd0, rdy0}, 32'd1);
      v0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0020;
      @(posedge clock);
      #1;
      v0 = 1'b0;
      check("d0_retain_valid", {31'd0, rv0}, 32'd1);
      check("d0_retain_data", {16'd0, rdata0}, 32'h0000AAAA);
      @(posedge clock);
      #1;
      check("d0_no_extra_rsp", {31'd0, rv0}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/word_mem_rw.md
Name: word_mem_rw

Overview:
- Parametrised successor to the node's byte-addressed word memory, which holds the routing tables (knownSinks, neighborID, qValue, HCM, ...).
- Keeps byte addressing and big-endian word assembly.
- Adds:
  - configurable word width and depth;
  - per-byte write enables;
  - a registered read with a valid/ready request channel;
  - out-of-range error reporting;
  - an optional post-reset clear sequencer.
- Sits between the node's algorithm FSMs and the table storage.

Parameters:
ADDR_WIDTH, 16, request address width (byte address)
MEM_DEPTH, 2048, storage size in bytes; must be ≥ WORD_BYTES and ≤ 2^ADDR_WIDTH
WORD_BYTES, 2, bytes per word; data width = 8*WORD_BYTES
CLEAR_ON_RESET, 1, 1 = zero every byte after reset before accepting requests; 0 = skip straight to IDLE

Ports:
clock  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_wr  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  byte address of word MSB
req_wdata  input  8*WORD_BYTES  write data, big-endian
req_be  input  WORD_BYTES  byte enables; bit WORD_BYTES-1 → byte at req_addr
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  8*WORD_BYTES  read data (zero for writes and errors)
rsp_err  output  1  request touched a byte ≥ MEM_DEPTH
busy  output  1  clear sequence in progress

Behaviour:
- Reset (nrst low, asynchronous):
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=CLEAR_ON_RESET.
  - State goes to INIT if CLEAR_ON_RESET, else IDLE. Clear counter goes to 0.
  - The storage array itself is not reset asynchronously.
- States: INIT, IDLE.
  - INIT: busy=1, req_ready=0. Each cycle writes 0 to byte[clr_cnt] and increments clr_cnt. The cycle that writes byte MEM_DEPTH-1 moves to IDLE. INIT therefore lasts exactly MEM_DEPTH cycles after nrst rises.
  - IDLE: busy=0, req_ready=1 every cycle. A request is accepted when req_valid && req_ready.
- Byte mapping: word byte k (k=0 is MSB) is at address req_addr+k. The address is computed at ADDR_WIDTH+1 bits, so there is no wrap-around.
  - Unaligned addresses are legal.
- Error rule: if req_addr+WORD_BYTES-1 ≥ MEM_DEPTH, the request is an error.
  - No byte is written, even in-range bytes.
  - rsp_rdata=0 and rsp_err=1.
- Write, accepted in cycle N:
  - Byte k is updated at the edge ending cycle N iff req_be[WORD_BYTES-1-k]=1.
  - req_be=0 is legal and is a no-op write.
  - rsp_valid=1 in cycle N+1, with rsp_rdata=0 and rsp_err per the error rule.
- Read, accepted in cycle N: rsp_valid=1 in cycle N+1, carrying rsp_rdata = {byte[a], byte[a+1], ...} as sampled at the end of cycle N.
- Responses:
  - Throughput is one request per cycle, fully pipelined, with no response backpressure.
  - rsp_valid is low in any cycle that does not follow an accepted request.
  - rsp_rdata and rsp_err hold their last values while rsp_valid=0.
- Ordering: a read accepted in cycle N+1 to bytes written by a write accepted in cycle N returns the new data.
- Overlapping unaligned writes in consecutive cycles: the later write wins per byte.
- req_valid in INIT is ignored; no response is produced.
- Reset mid-operation (INIT or IDLE):
  - Any pending response is dropped, and rsp_valid is low from reset assertion.
  - After release, INIT restarts from byte 0.
  - A write whose clock edge coincides with nrst falling has undefined effect on that word only.
- The storage array is inferable as a byte-wide RAM. No combinational path from req_* to rsp_*.

Test Plan:
- MEM_DEPTH=64, CLEAR_ON_RESET=1: release nrst → busy=1 and req_ready=0 for exactly 64 cycles. Then read addr 0x3E → rsp_rdata=0x0000, rsp_err=0 one cycle after accept.
- Write addr 0x08, data 0x00AB, be=2'b11. Read addr 0x08 the next cycle → 0x00AB. Read addr 0x09 → 0xAB00 (unaligned, byte 0x0A is zero).
- Byte enables: write 0x1234 at 0x10 with be=11, then write 0xFFFF with be=01. Read 0x10 → 0x12FF. Write with be=00 → data unchanged, rsp_valid=1, rsp_err=0.
- Out of range, depth 64: write 0xBEEF at 0x3F → rsp_err=1, byte 0x3F remains 0. Read 0x3F → rsp_err=1, rsp_rdata=0. Read 0x40 → rsp_err=1.
- Back-to-back: accept W(0x20,0x5555), R(0x20), W(0x20,0xAAAA), R(0x20) on consecutive cycles → four consecutive rsp_valid pulses, with read data 0x5555 then 0xAAAA.
- Reset mid-stream: assert nrst during a read accept → rsp_valid stays 0. After release, INIT repeats (busy high for 64 cycles) and previously written 0x20 reads 0x0000. With CLEAR_ON_RESET=0 → req_ready=1 in the first cycle after release and 0x20 retains 0xAAAA.
